// File: rtl/forward_scoreboard_pkg.sv
// Shared pipeline constants for the forwarding scoreboard.
//   REG_W      : architectural register index width
//   TW_DEFAULT : default width of Tnew/Tuse fields
//   SEL_*      : forwarding-select encodings (0 = register file, k = stage k)
package forward_scoreboard_pkg;

  localparam int unsigned REG_W      = 5;
  localparam int unsigned TW_DEFAULT = 2;

  localparam int unsigned SEL_RF = 0;
  localparam int unsigned SEL_E  = 1;
  localparam int unsigned SEL_M  = 2;
  localparam int unsigned SEL_W  = 3;

endpackage : forward_scoreboard_pkg

// File: rtl/fwd_match.sv
// Per-source matcher: finds the youngest in-flight producer of one D-stage
// source register and flags a hazard if its result is not ready in time.
//   src_i    : source register index (0 = no dependency)
//   tuse_i   : cycles until the source is consumed
//   vld_i    : per-stage entry valid (bit 0 = E)
//   dst_i    : per-stage destination register
//   tnew_i   : per-stage cycles until result is forwardable
//   sel_o    : 0 = regfile, k = stage k (combinational)
//   hazard_o : selected producer not ready (combinational)
module fwd_match
  import forward_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned TW    = TW_DEFAULT,
  parameter int unsigned SW    = $clog2(DEPTH + 1)
) (
  input  logic [REG_W-1:0]            src_i,
  input  logic [TW-1:0]               tuse_i,
  input  logic [DEPTH-1:0]            vld_i,
  input  logic [DEPTH-1:0][REG_W-1:0] dst_i,
  input  logic [DEPTH-1:0][TW-1:0]    tnew_i,
  output logic [SW-1:0]               sel_o,
  output logic                        hazard_o
);

  // Scan oldest to youngest so the lowest matching stage wins.
  always_comb begin
    sel_o    = SW'(SEL_RF);
    hazard_o = 1'b0;
    if (src_i != '0) begin
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (vld_i[k] && (dst_i[k] == src_i)) begin
          sel_o    = SW'(k + 1);
          hazard_o = (tnew_i[k] > tuse_i);
        end
      end
    end
  end

endmodule : fwd_match

// File: rtl/forward_scoreboard.sv
// Tnew/Tuse forwarding scoreboard for an in-order pipeline. Tracks producers
// in E..W, selects forwarding sources for the D-stage instruction, and
// raises stall on data or mult/div hazards.
// Optional feature: define FWD_SCOREBOARD_MD_EN to enable the mult/div busy
// counter; otherwise d_md_use/e_md_start are ignored and md_busy is 0.
//   clk, rst_n  : clock, asynchronous active-low reset
//   d_*         : D-stage instruction (valid, dst, tnew, sources, tuse, md use)
//   e_md_start  : E-stage instruction starts mult/div
//   flush_e     : kill the E entry this cycle
//   stall       : freeze PC/D, bubble into E (combinational)
//   fwd_sel     : per-source forwarding select (combinational)
//   md_busy     : mult/div in progress (combinational)
module forward_scoreboard
  import forward_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned TW      = TW_DEFAULT,
  parameter int unsigned MD_LAT  = 5
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 d_valid,
  input  logic [REG_W-1:0]                     d_dst,
  input  logic [TW-1:0]                        d_tnew,
  input  logic [NUM_SRC*REG_W-1:0]             d_src,
  input  logic [NUM_SRC*TW-1:0]                d_tuse,
  input  logic                                 d_md_use,
  input  logic                                 e_md_start,
  input  logic                                 flush_e,
  output logic                                 stall,
  output logic [NUM_SRC*$clog2(DEPTH+1)-1:0]   fwd_sel,
  output logic                                 md_busy
);

  localparam int unsigned SW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]            vld_q,  vld_d;
  logic [DEPTH-1:0][REG_W-1:0] dst_q,  dst_d;
  logic [DEPTH-1:0][TW-1:0]    tnew_q, tnew_d;

  logic [NUM_SRC-1:0]    src_haz;
  logic [NUM_SRC*SW-1:0] sel_raw;
  logic                  md_busy_raw;
  logic                  md_haz;
  logic                  stall_raw;

  // One matcher per source port.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_match
    fwd_match #(
      .DEPTH (DEPTH),
      .TW    (TW),
      .SW    (SW)
    ) u_match (
      .src_i    (d_src[i*REG_W +: REG_W]),
      .tuse_i   (d_tuse[i*TW +: TW]),
      .vld_i    (vld_q),
      .dst_i    (dst_q),
      .tnew_i   (tnew_q),
      .sel_o    (sel_raw[i*SW +: SW]),
      .hazard_o (src_haz[i])
    );
  end

`ifdef FWD_SCOREBOARD_MD_EN
  localparam int unsigned CW = $clog2(MD_LAT + 1);

  logic [CW-1:0] md_cnt_q, md_cnt_d;

  // The start cycle is itself the first busy cycle, so the counter holds
  // the busy cycles remaining after it; a restart always reloads.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (e_md_start) begin
      md_cnt_d = CW'(MD_LAT - 1);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign md_busy_raw = (md_cnt_q != '0) | e_md_start;
  assign md_haz      = d_md_use & md_busy_raw;
`else
  logic unused_md;
  assign unused_md   = d_md_use ^ e_md_start;
  assign md_busy_raw = 1'b0;
  assign md_haz      = 1'b0;
`endif

  assign stall_raw = d_valid & ((|src_haz) | md_haz);

  // Held quiet during reset so live D/E inputs cannot leak through.
  assign stall   = rst_n & stall_raw;
  assign fwd_sel = rst_n ? sel_raw : '0;
  assign md_busy = rst_n & md_busy_raw;

  // Pipeline shift: E loads from D (bubble on stall/flush), a flushed E
  // entry dies instead of moving to M, tnew counts down to 0.
  always_comb begin
    vld_d  = '0;
    dst_d  = '0;
    tnew_d = '0;
    vld_d[0] = d_valid & ~stall_raw & ~flush_e;
    if (vld_d[0]) begin
      dst_d[0]  = d_dst;
      tnew_d[0] = d_tnew;
    end
    for (int k = 1; k < int'(DEPTH); k++) begin
      vld_d[k]  = (k == 1) ? (vld_q[0] & ~flush_e) : vld_q[k-1];
      dst_d[k]  = dst_q[k-1];
      tnew_d[k] = (tnew_q[k-1] == '0) ? '0 : (tnew_q[k-1] - TW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      dst_q  <= '0;
      tnew_q <= '0;
    end else begin
      vld_q  <= vld_d;
      dst_q  <= dst_d;
      tnew_q <= tnew_d;
    end
  end

endmodule : forward_scoreboard

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard with default parameters.
// Mult/div expectations follow whether FWD_SCOREBOARD_MD_EN is defined.
module tb_forward_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       d_valid;
  logic [4:0] d_dst;
  logic [1:0] d_tnew;
  logic [9:0] d_src;
  logic [3:0] d_tuse;
  logic       d_md_use;
  logic       e_md_start;
  logic       flush_e;
  logic       stall;
  logic [3:0] fwd_sel;
  logic       md_busy;

`ifdef FWD_SCOREBOARD_MD_EN
  localparam logic MD = 1'b1;
`else
  localparam logic MD = 1'b0;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  forward_scoreboard dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_valid    (d_valid),
    .d_dst      (d_dst),
    .d_tnew     (d_tnew),
    .d_src      (d_src),
    .d_tuse     (d_tuse),
    .d_md_use   (d_md_use),
    .e_md_start (e_md_start),
    .flush_e    (flush_e),
    .stall      (stall),
    .fwd_sel    (fwd_sel),
    .md_busy    (md_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [4:0] dst, input logic [1:0] tn,
                     input logic [4:0] s0, input logic [1:0] u0,
                     input logic [4:0] s1, input logic [1:0] u1);
    d_valid = v;
    d_dst   = dst;
    d_tnew  = tn;
    d_src   = {s1, s0};
    d_tuse  = {u1, u0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with busy-looking D inputs
    rst_n      = 1'b0;
    flush_e    = 1'b0;
    d_md_use   = 1'b1;
    e_md_start = 1'b1;
    drv(1'b1, 5'd7, 2'd2, 5'd1, 2'd0, 5'd3, 2'd0);
    #12;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_fwd", 32'(fwd_sel), 32'd0);
    chk("rst_md_busy", 32'(md_busy), 32'd0);

    @(negedge clk);
    rst_n      = 1'b1;
    e_md_start = 1'b0;
    d_md_use   = 1'b0;

    // $0 producer never matches
    drv(1'b1, 5'd0, 2'd2, 5'd0, 2'd0, 5'd0, 2'd0);
    tick();
    drv(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    #1;
    chk("r0_stall", 32'(stall), 32'd0);
    chk("r0_fwd", 32'(fwd_sel), 32'd0);

    // lw $1 (tnew=2) then add $2,$1,$3 (tuse=1)
    drv(1'b1, 5'd1, 2'd2, 5'd0, 2'd0, 5'd0, 2'd0);
    tick();
    drv(1'b1, 5'd2, 2'd1, 5'd1, 2'd1, 5'd3, 2'd1);
    #1;
    chk("lw_use_stall", 32'(stall), 32'd1);
    chk("lw_use_fwd_e", 32'(fwd_sel), 32'h1);
    tick();
    chk("lw_use_release", 32'(stall), 32'd0);
    chk("lw_use_fwd_m", 32'(fwd_sel), 32'h2);

    // add $2 -> W, addu $1 -> M, ori $1 -> E; beq $1,$2 (tuse=0)
    drv(1'b1, 5'd2, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0);
    tick();
    drv(1'b1, 5'd1, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0);
    tick();
    drv(1'b1, 5'd1, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0);
    tick();
    drv(1'b1, 5'd0, 2'd0, 5'd1, 2'd0, 5'd2, 2'd0);
    #1;
    chk("beq_stall", 32'(stall), 32'd1);
    chk("beq_fwd_e_w", 32'(fwd_sel), 32'hd);
    tick();
    chk("beq_release", 32'(stall), 32'd0);
    chk("beq_fwd_m", 32'(fwd_sel), 32'h2);

    // flush lw $4 in E while D uses $4
    drv(1'b1, 5'd4, 2'd2, 5'd0, 2'd0, 5'd0, 2'd0);
    tick();
    drv(1'b1, 5'd0, 2'd0, 5'd4, 2'd0, 5'd0, 2'd0);
    flush_e = 1'b1;
    #1;
    chk("flush_stall", 32'(stall), 32'd1);
    chk("flush_fwd_e", 32'(fwd_sel), 32'h1);
    tick();
    flush_e = 1'b0;
    #1;
    chk("flush_after_stall", 32'(stall), 32'd0);
    chk("flush_after_fwd", 32'(fwd_sel), 32'h0);

    // mult/div start then mfhi for 5 cycles
    drv(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    e_md_start = 1'b1;
    #1;
    chk("md_start_busy", 32'(md_busy), 32'(MD));
    tick();
    e_md_start = 1'b0;
    d_md_use   = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("md_stall_c%0d", c), 32'(stall), 32'(MD && (c <= 4)));
      chk($sformatf("md_busy_c%0d", c), 32'(md_busy), 32'(MD && (c <= 4)));
      tick();
    end
    d_md_use = 1'b0;

    // Reset mid-cycle during a data stall with mult/div busy
    drv(1'b1, 5'd5, 2'd2, 5'd0, 2'd0, 5'd0, 2'd0);
    tick();
    drv(1'b1, 5'd0, 2'd0, 5'd5, 2'd0, 5'd0, 2'd0);
    d_md_use   = 1'b1;
    e_md_start = 1'b1;
    #1;
    chk("pre_rst_stall", 32'(stall), 32'd1);
    chk("pre_rst_busy", 32'(md_busy), 32'(MD));
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_busy", 32'(md_busy), 32'd0);
    chk("mid_rst_fwd", 32'(fwd_sel), 32'd0);
    e_md_start = 1'b0;
    rst_n      = 1'b1;
    #1;
    chk("post_rst_stall", 32'(stall), 32'd0);
    chk("post_rst_fwd", 32'(fwd_sel), 32'd0);
    chk("post_rst_busy", 32'(md_busy), 32'd0);
    tick();
    chk("post_rst_stall_2", 32'(stall), 32'd0);
    chk("post_rst_fwd_2", 32'(fwd_sel), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_forward_scoreboard
